apb1_cmd_master: RTL and testbench
==================================

Name: apb1_cmd_master

Overview:
- APB initiator for the APB1 peripheral domain: converts a simple valid/ready command stream into APB4 SETUP/ACCESS transfers.
- Drives the psel/penable/paddr/pwdata/pstrb/pprot bus that feeds the APB1 slave mux.
- Returns read data and error status on a held response channel.
- Used for DMA-style register sequencing and bench-side bus driving inside the APB1 clock domain.

Parameters:
- ADDR_W, 32, width of cmd_addr and paddr.
- DATA_W, 32, width of write/read data; pstrb width is DATA_W/8.
- TIMEOUT_CYCLES, 256, ACCESS-phase wait-state limit; used only with the optional feature; legal range 2..65535.

Ports:
- apb1_root_clk  in  1  the only clock.
- apb1_root_rst  in  1  reset, synchronous and active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at a rising edge.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data.
- cmd_strb  in  DATA_W/8  write byte strobes.
- cmd_prot  in  3  protection attributes.
- paddr  out  ADDR_W  APB address.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- pwdata  out  DATA_W  APB write data.
- pstrb  out  DATA_W/8  APB strobes.
- pprot  out  3  APB protection.
- prdata  in  DATA_W  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB error.
- rsp_valid  out  1  response held until accepted.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
- rsp_rdata  out  DATA_W  captured read data; 0 for writes.
- rsp_err  out  1  pslverr captured, or timeout.
- rsp_timeout  out  1  transfer aborted by timeout; constant 0 without the optional feature.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: all outputs 0, state IDLE. cmd_ready is also 0 while apb1_root_rst is high.
- States: IDLE, SETUP, ACCESS. All APB outputs are registered.
- cmd_ready = !rst & (state == IDLE) & (!rsp_valid | rsp_ready). A response may be consumed and a new command accepted on the same edge.
- On accept (edge N), the state goes to SETUP:
  - psel=1, penable=0.
  - paddr, pwrite, pwdata, pprot latched from the command.
  - pstrb = cmd_strb for writes, forced 0 for reads.
  - pwdata forced 0 for reads.
- SETUP always moves to ACCESS on the next edge (N+1 -> N+2 has penable=1).
- ACCESS: paddr/pwrite/pwdata/pstrb/pprot stay stable. Wait for pready=1 at an edge; then, on that edge:
  - psel=0, penable=0.
  - rsp_valid=1, rsp_err=pslverr, rsp_rdata = prdata for reads, 0 for writes.
  - State returns to IDLE.
- pslverr and prdata are sampled only in ACCESS with pready=1; ignored otherwise.
- Minimum latency with pready=1 in the first ACCESS cycle: accept at N, rsp_valid visible N+3.
- Back-to-back with rsp_ready=1: next SETUP at N+4; psel is low for one cycle between transfers.
- rsp_* fields hold unchanged while rsp_valid & !rsp_ready. rsp_valid clears on handshake unless a new response loads on the same edge, which cannot happen because a response requires a prior accept.
- Reset mid-transfer: the next edge forces IDLE with psel/penable=0. An in-flight transfer is dropped with no response, and a pending response is discarded.
- cmd_addr is passed unmodified, with no alignment checking.

Optional Feature:
- Macro: APB1_MST_TIMEOUT_EN.
- With it defined:
  - A counter clears on entry to ACCESS and increments on each ACCESS cycle with pready=0.
  - When the counter reaches TIMEOUT_CYCLES-1 with pready still 0, the next edge aborts the transfer: psel/penable=0, rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0, state IDLE.
  - If pready=1 arrives on the same edge as the abort, normal completion wins.
- Without it: rsp_timeout is tied 0, there is no counter, and ACCESS waits indefinitely.

Decomposition:
- Package apb1_pkg:
  - state encoding constants (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2);
  - default ADDR_W/DATA_W;
  - PPROT bit position constants.
- One sub-module, apb1_mst_wdog: timeout counter with clear, count-enable and expire output. It is instantiated only under APB1_MST_TIMEOUT_EN.

Test Plan:
- Write, no wait: cmd addr=0x40001004, wdata=0xA5A5_1234, strb=0xF, pready=1. Expect psel high 2 cycles, penable high 1 cycle, rsp_valid at N+3, rsp_err=0, rsp_rdata=0.
- Read with 2 wait states: pready low for 2 ACCESS cycles, prdata=0xDEAD_BEEF on the third. Expect pstrb=0, paddr stable for 4 cycles, rsp_rdata=0xDEAD_BEEF.
- Slave error: write with pslverr=1 and pready=1. Expect rsp_err=1. pslverr=1 asserted during wait cycles must be ignored.
- Back-to-back with response backpressure:
  - Two queued commands with rsp_ready held 0 for 5 cycles: the second command is not accepted until the first response is consumed, and rsp_* hold unchanged.
  - Same stream with rsp_ready=1: a 1-cycle psel gap between transfers.
- Timeout (APB1_MST_TIMEOUT_EN, TIMEOUT_CYCLES=4): pready held 0. Expect abort after 4 ACCESS cycles with rsp_err=1, rsp_timeout=1. Without the macro, the bus stays in ACCESS for 100 cycles.
- Reset mid-ACCESS: assert apb1_root_rst for 1 cycle while pready=0. Expect psel/penable=0 after the edge, no rsp_valid, and a fresh command accepted normally afterwards.

Source files
------------

// File: rtl/apb1_pkg.sv
// Shared definitions for the APB1 command master: FSM encoding, default bus widths
// and PPROT bit positions.
package apb1_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb1_state_e;

  localparam int APB1_ADDR_W = 32;
  localparam int APB1_DATA_W = 32;

  localparam int PPROT_PRIV  = 0;
  localparam int PPROT_NSEC  = 1;
  localparam int PPROT_INSTR = 2;

endpackage

// File: rtl/apb1_mst_wdog.sv
// ACCESS-phase wait-state watchdog; expires once TIMEOUT_CYCLES-1 stalled cycles
// have been counted since the last clear.
module apb1_mst_wdog #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  logic [15:0] cnt_q, cnt_d;

  assign expire_o = (cnt_q == 16'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expire_o) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/apb1_cmd_master.sv
// APB4 initiator: valid/ready command in, SETUP/ACCESS transfer out, held response back.
// Optional ACCESS wait-state timeout enabled by defining APB1_MST_TIMEOUT_EN.
module apb1_cmd_master
  import apb1_pkg::*;
#(
  parameter int ADDR_W         = APB1_ADDR_W,
  parameter int DATA_W         = APB1_DATA_W,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  apb1_root_clk,
  input  logic                  apb1_root_rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_strb,
  input  logic [2:0]            cmd_prot,
  output logic [ADDR_W-1:0]     paddr,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [DATA_W-1:0]     pwdata,
  output logic [DATA_W/8-1:0]   pstrb,
  output logic [2:0]            pprot,
  input  logic [DATA_W-1:0]     prdata,
  input  logic                  pready,
  input  logic                  pslverr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout
);

  localparam int STRB_W = DATA_W / 8;

  apb1_state_e         state_q, state_d;
  logic                psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [STRB_W-1:0]   pstrb_q, pstrb_d;
  logic [2:0]          pprot_q, pprot_d;
  logic                rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                wd_expire;

`ifdef APB1_MST_TIMEOUT_EN
  logic rsp_to_q, rsp_to_d;

  // Counter restarts whenever we are outside ACCESS, so it reads 0 on ACCESS entry.
  apb1_mst_wdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .clk_i    (apb1_root_clk),
    .rst_i    (apb1_root_rst),
    .clr_i    (state_q != ACCESS),
    .en_i     ((state_q == ACCESS) && !pready),
    .expire_o (wd_expire)
  );
  assign rsp_timeout = rsp_to_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign wd_expire   = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  assign cmd_ready = !apb1_root_rst && (state_q == IDLE) && (!rsp_valid_q || rsp_ready);

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    pprot_d     = pprot_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
`ifdef APB1_MST_TIMEOUT_EN
    rsp_to_d    = rsp_to_q;
`endif
    if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_d   = SETUP;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          paddr_d   = cmd_addr;
          pwrite_d  = cmd_write;
          pprot_d   = cmd_prot;
          pwdata_d  = cmd_write ? cmd_wdata : '0;
          pstrb_d   = cmd_write ? cmd_strb : '0;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        // A ready slave takes priority over a watchdog expiring on the same edge.
        if (pready) begin
          state_d     = IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = pslverr;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
`ifdef APB1_MST_TIMEOUT_EN
          rsp_to_d    = 1'b0;
`endif
        end else if (wd_expire) begin
          state_d     = IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
`ifdef APB1_MST_TIMEOUT_EN
          rsp_to_d    = 1'b1;
`endif
        end
      end
      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge apb1_root_clk) begin
    if (apb1_root_rst) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      pprot_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef APB1_MST_TIMEOUT_EN
      rsp_to_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      pprot_q     <= pprot_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef APB1_MST_TIMEOUT_EN
      rsp_to_q    <= rsp_to_d;
`endif
    end
  end

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign pstrb     = pstrb_q;
  assign pprot     = pprot_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb1_cmd_master.sv
// Bench for apb1_cmd_master: directed vector table, hand-written corner sequences and
// randomized transfers checked against a transaction-level model.
module tb_apb1_cmd_master;
  import apb1_pkg::*;

  localparam int TMO = 4;
`ifdef APB1_MST_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_strb = '0;
  logic [2:0]  cmd_prot = '0;
  logic [31:0] paddr, pwdata, prdata = '0, rsp_rdata;
  logic        psel, penable, pwrite, pready = 1'b0, pslverr = 1'b0;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err, rsp_timeout;

  always #5 clk = ~clk;

  apb1_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO)) dut (
    .apb1_root_clk(clk), .apb1_root_rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          waits;
    bit          serr;
    logic [31:0] rdata;
    int          pre_delay;
    bit          exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Model of the response currently held by the DUT
  bit          rsp_pend = 1'b0;
  bit          pend_err, pend_to;
  logic [31:0] pend_rdata;
  // Model of the transfer currently on the bus
  bit          cur_wr;
  logic [31:0] cur_addr, cur_wdata;
  logic [3:0]  cur_strb;
  logic [2:0]  cur_prot;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bus(input string ph, input bit en);
    chk({ph, "_psel"}, psel, 1'b1);
    chk({ph, "_penable"}, penable, en);
    chk({ph, "_paddr"}, paddr, cur_addr);
    chk({ph, "_pwrite"}, pwrite, cur_wr);
    chk({ph, "_pwdata"}, pwdata, cur_wr ? cur_wdata : 32'h0);
    chk({ph, "_pstrb"}, pstrb, cur_wr ? cur_strb : 4'h0);
    chk({ph, "_pprot"}, pprot, cur_prot);
    chk({ph, "_rsp_valid"}, rsp_valid, 1'b0);
  endtask

  task automatic issue(input vec_t v);
    bit acc;
    bit aborted;
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
    cmd_strb = v.strb; cmd_prot = v.prot;
    acc = 1'b0;
    for (int k = 0; k <= v.pre_delay + 1; k++) begin
      rsp_ready = (k >= v.pre_delay);
      #1;
      chk("cmd_ready", cmd_ready, !rsp_pend || rsp_ready);
      chk("idle_psel", psel, 1'b0);
      if (rsp_pend) begin
        chk("hold_valid", rsp_valid, 1'b1);
        chk("hold_rdata", rsp_rdata, pend_rdata);
        chk("hold_err", rsp_err, pend_err);
        chk("hold_timeout", rsp_timeout, pend_to);
      end
      acc = cmd_ready;
      step();
      if (rsp_ready) rsp_pend = 1'b0;
      if (acc) break;
    end
    chk("accepted", acc, 1'b1);
    if (!acc) return;
    cur_wr = v.wr; cur_addr = v.addr; cur_wdata = v.wdata; cur_strb = v.strb; cur_prot = v.prot;
    // Scramble the command inputs to prove the bus fields are latched
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_addr = ~v.addr; cmd_wdata = ~v.wdata; cmd_strb = ~v.strb; cmd_prot = ~v.prot;
    cmd_write = ~v.wr;
    check_bus("setup", 1'b0);
    step();
    check_bus("access", 1'b1);
    aborted = 1'b0;
    for (int w = 0; w < v.waits; w++) begin
      pready = 1'b0; pslverr = 1'b1; prdata = $urandom;
      step();
      if (TO_EN && w == TMO - 1) begin
        aborted = 1'b1;
        break;
      end
      check_bus("wait", 1'b1);
    end
    if (!aborted) begin
      pready = 1'b1; pslverr = v.serr; prdata = v.rdata;
      step();
    end
    pready = 1'b0; pslverr = 1'b0;
    chk("done_psel", psel, 1'b0);
    chk("done_penable", penable, 1'b0);
    chk("done_rsp_valid", rsp_valid, 1'b1);
    rsp_pend   = 1'b1;
    pend_err   = aborted ? 1'b1 : v.exp_err;
    pend_rdata = aborted ? 32'h0 : v.exp_rdata;
    pend_to    = aborted;
    chk("rsp_err", rsp_err, pend_err);
    chk("rsp_rdata", rsp_rdata, pend_rdata);
    chk("rsp_timeout", rsp_timeout, pend_to);
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("drain_valid", rsp_valid, 1'b0);
    rsp_pend = 1'b0;
  endtask

  vec_t tbl[6];
  vec_t rv;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench timeout");
  end

  initial begin
    tbl[0] = '{1'b1, 32'h4000_1004, 32'hA5A5_1234, 4'hF, 3'h0, 0, 1'b0, 32'h1111_2222, 0, 1'b0, 32'h0};
    tbl[1] = '{1'b0, 32'h4000_2008, 32'h5555_AAAA, 4'hF, 3'(1 << PPROT_PRIV), 2, 1'b0, 32'hDEAD_BEEF, 1, 1'b0, 32'hDEAD_BEEF};
    tbl[2] = '{1'b1, 32'h4000_3000, 32'h0BAD_F00D, 4'h5, 3'(1 << PPROT_NSEC), 1, 1'b1, 32'h7777_7777, 0, 1'b1, 32'h0};
    tbl[3] = '{1'b0, 32'h4000_0103, 32'h0, 4'h3, 3'(1 << PPROT_INSTR), 0, 1'b0, 32'h1234_5678, 0, 1'b0, 32'h1234_5678};
    tbl[4] = '{1'b1, 32'h4000_0200, 32'hCAFE_0001, 4'hC, 3'h7, 0, 1'b0, 32'h9999_0000, 5, 1'b0, 32'h0};
    tbl[5] = '{1'b0, 32'h4000_0300, 32'h0, 4'h0, 3'h2, 1, 1'b1, 32'h600D_0BAD, 2, 1'b1, 32'h600D_0BAD};

    // Reset state, with a command offered while reset is high
    cmd_valid = 1'b1;
    repeat (2) step();
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_psel", psel, 1'b0);
    chk("rst_penable", penable, 1'b0);
    chk("rst_paddr", paddr, 32'h0);
    chk("rst_pwrite", pwrite, 1'b0);
    chk("rst_pwdata", pwdata, 32'h0);
    chk("rst_pstrb", pstrb, 4'h0);
    chk("rst_pprot", pprot, 3'h0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_rsp_timeout", rsp_timeout, 1'b0);
    cmd_valid = 1'b0;
    rst = 1'b0;
    step();

    for (int i = 0; i < 6; i++) issue(tbl[i]);

    // Reset discards a pending response and blocks acceptance
    rst = 1'b1; rsp_ready = 1'b1; cmd_valid = 1'b1;
    #1;
    chk("rstpend_cmd_ready", cmd_ready, 1'b0);
    step();
    rst = 1'b0; rsp_ready = 1'b0; cmd_valid = 1'b0;
    chk("rstpend_rsp_valid", rsp_valid, 1'b0);
    chk("rstpend_psel", psel, 1'b0);
    rsp_pend = 1'b0;

    // Back-to-back stream with rsp_ready held high: one-cycle psel gap
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h4000_0040; cmd_wdata = 32'h1;
    cmd_strb = 4'hF; rsp_ready = 1'b1; pready = 1'b1; pslverr = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step();
      chk("b2b_psel", psel, (i % 3) != 2);
      chk("b2b_rsp_valid", rsp_valid, (i % 3) == 2);
    end
    cmd_valid = 1'b0;
    step();
    chk("b2b_drain", rsp_valid, 1'b0);
    rsp_ready = 1'b0; pready = 1'b0;

    // Long stall: times out with the watchdog, otherwise waits it out
    rv = '{1'b0, 32'h4000_0500, 32'h0, 4'h0, 3'h0, 100, 1'b0, 32'hFACE_FEED, 0, 1'b0, 32'hFACE_FEED};
    issue(rv);
    drain();

    // Reset mid-ACCESS: transfer dropped, no response
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h4000_0600;
    step();
    cmd_valid = 1'b0;
    step();
    pready = 1'b0;
    step();
    chk("midrst_penable_before", penable, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_psel", psel, 1'b0);
    chk("midrst_penable", penable, 1'b0);
    chk("midrst_rsp_valid", rsp_valid, 1'b0);
    step();
    chk("midrst_rsp_valid2", rsp_valid, 1'b0);
    issue(tbl[0]);

    // Randomized transfers against the transaction model
    for (int i = 0; i < 40; i++) begin
      rv.wr        = 1'($urandom_range(0, 1));
      rv.addr      = $urandom;
      rv.wdata     = $urandom;
      rv.strb      = 4'($urandom);
      rv.prot      = 3'($urandom);
      rv.waits     = $urandom_range(0, 5);
      rv.serr      = 1'($urandom_range(0, 1));
      rv.rdata     = $urandom;
      rv.pre_delay = $urandom_range(0, 3);
      rv.exp_err   = rv.serr;
      rv.exp_rdata = rv.wr ? 32'h0 : rv.rdata;
      issue(rv);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
